// File: rtl/pipeline_interlock_if.sv
// Stage-status and interlock-control bundle between the 5-stage datapath and
// its hazard controller.
interface pipeline_interlock_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [5:0]       id_rs1;
   logic [5:0]       id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic             id_fpu_multi;
   logic             ex_valid;
   logic             ex_we;
   logic [5:0]       ex_rd;
   logic             ex_is_load;
   logic             ex_redirect;
   logic             mem_valid;
   logic             mem_we;
   logic [5:0]       mem_rd;
   logic             wb_valid;
   logic             wb_we;
   logic [5:0]       wb_rd;
   logic             stall_front;
   logic             bubble_ex;
   logic             freeze_ex;
   logic             bubble_mem;
   logic             flush_id;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic             fpu_start;
   logic             fpu_busy;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_fpu_multi,
             ex_valid, ex_we, ex_rd, ex_is_load, ex_redirect,
             mem_valid, mem_we, mem_rd, wb_valid, wb_we, wb_rd,
      input  stall_front, bubble_ex, freeze_ex, bubble_mem, flush_id,
             fwd_a_sel, fwd_b_sel, fpu_start, fpu_busy, stall_count
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_fpu_multi,
             ex_valid, ex_we, ex_rd, ex_is_load, ex_redirect,
             mem_valid, mem_we, mem_rd, wb_valid, wb_we, wb_rd,
      output stall_front, bubble_ex, freeze_ex, bubble_mem, flush_id,
             fwd_a_sel, fwd_b_sel, fpu_start, fpu_busy, stall_count
   );
endinterface

// File: rtl/pipeline_interlock.sv
// Hazard/forwarding/flush controller with multi-cycle FPU sequencing and a stall counter.
// Define INTERLOCK_FWD_EN to enable operand forwarding; otherwise every RAW match stalls.
module pipeline_interlock #(
   parameter int FPU_LAT = 4,
   parameter int CNT_W   = 16
) (
   input logic                clk,
   input logic                reset,
   pipeline_interlock_if.slave bus
);
   localparam int CW    = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
   localparam bit MULTI = (FPU_LAT > 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             fpu_start_r;
   logic [CNT_W-1:0] stall_count_r;

   logic ex_a, mem_a, wb_a, ex_b, mem_b, wb_b;
   logic busy, redir, load_use, hazard, issue;
   logic stall_front, bubble_ex;

   function automatic logic match(input logic rd_en, input logic v, input logic we,
                                  input logic [5:0] src, input logic [5:0] rd);
      return rd_en && v && we && (src == rd) && (src != 6'd0);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic ex, input logic mem, input logic wb);
      if (ex)       return 2'b01;
      else if (mem) return 2'b10;
      else if (wb)  return 2'b11;
      else          return 2'b00;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign ex_a  = match(bus.id_use_rs1, bus.ex_valid,  bus.ex_we,  bus.id_rs1, bus.ex_rd);
   assign mem_a = match(bus.id_use_rs1, bus.mem_valid, bus.mem_we, bus.id_rs1, bus.mem_rd);
   assign wb_a  = match(bus.id_use_rs1, bus.wb_valid,  bus.wb_we,  bus.id_rs1, bus.wb_rd);
   assign ex_b  = match(bus.id_use_rs2, bus.ex_valid,  bus.ex_we,  bus.id_rs2, bus.ex_rd);
   assign mem_b = match(bus.id_use_rs2, bus.mem_valid, bus.mem_we, bus.id_rs2, bus.mem_rd);
   assign wb_b  = match(bus.id_use_rs2, bus.wb_valid,  bus.wb_we,  bus.id_rs2, bus.wb_rd);

   assign load_use = (ex_a || ex_b) && bus.ex_is_load;

`ifdef INTERLOCK_FWD_EN
   assign hazard        = load_use;
   assign bus.fwd_a_sel = fwd_sel(ex_a, mem_a, wb_a);
   assign bus.fwd_b_sel = fwd_sel(ex_b, mem_b, wb_b);
`else
   // No write-through in the regfile, so even a WB producer must drain first.
   assign hazard        = load_use || ex_a || mem_a || wb_a || ex_b || mem_b || wb_b;
   assign bus.fwd_a_sel = 2'b00;
   assign bus.fwd_b_sel = 2'b00;
`endif

   // State register, FPU occupancy counter, start pulse and stall counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         fpu_start_r   <= 1'b0;
         stall_count_r <= '0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         fpu_start_r <= issue;
         if (stall_front)
            stall_count_r <= sat_inc(stall_count_r);
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (issue && MULTI) begin
               state_nx = BUSY;
               cnt_nx   = CW'(FPU_LAT - 1);
            end
         end
         BUSY: begin
            cnt_nx = cnt - CW'(1);
            if (cnt == CW'(1))
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // While the FPU op owns EX, redirects and hazards are deferred behind the freeze.
   always_comb begin
      busy        = (state == BUSY);
      redir       = bus.ex_redirect && !busy;
      stall_front = busy || (hazard && !redir);
      bubble_ex   = !busy && (redir || hazard);
      issue       = bus.id_valid && bus.id_fpu_multi && !stall_front && !redir;
   end

   assign bus.stall_front = stall_front;
   assign bus.bubble_ex   = bubble_ex;
   assign bus.freeze_ex   = busy;
   assign bus.bubble_mem  = busy;
   assign bus.flush_id    = redir;
   assign bus.fpu_start   = fpu_start_r;
   assign bus.fpu_busy    = busy;
   assign bus.stall_count = stall_count_r;
endmodule
